kan_layer_sequencer: RTL and testbench
======================================

KAN_LAYER_SEQUENCER -- requirements
Module: kan_layer_sequencer

Interface
REQ-001 SHALL have parameters: ADDRWIDTH, 32, address width; LG_LAYERSIZE, 12, layer-size width; MAX_LAYERS, 8, descriptor table depth; LG_MAX_LAYERS, 3, log2(MAX_LAYERS); KERNEL_MULT, 5, kernel input-count multiplier; ZERO_ADDRESS, 32'h00070000, zero-page address.
REQ-002 SHALL use one clock; reset is asynchronous and active-low: s_axis_aclk  in  1  clock; s_axis_aresetn  in  1  async active-low reset.
REQ-003 cfg_we  in  1  descriptor write strobe.
REQ-004 cfg_idx  in  LG_MAX_LAYERS  descriptor index.
REQ-005 cfg_base_address  in  ADDRWIDTH  layer weight base address.
REQ-006 cfg_input_layersize  in  LG_LAYERSIZE  layer input count.
REQ-007 cfg_output_layersize  in  LG_LAYERSIZE  layer output count.
REQ-008 cfg_num_layers  in  LG_MAX_LAYERS+1  layers per run, sampled at start.
REQ-009 start  in  1  run request; abort  in  1  cancel run.
REQ-010 layer_done  in  1  current layer complete (one-cycle pulse from kernel output tlast handshake).
REQ-011 layer_start  out  1  one-cycle launch pulse to loader/kernel.
REQ-012 layer_base_address  out  ADDRWIDTH; layer_zero_address  out  ADDRWIDTH; layer_input_layersize  out  LG_LAYERSIZE; layer_output_layersize  out  LG_LAYERSIZE; kernel_input_count  out  LG_LAYERSIZE+3; layer_index  out  LG_MAX_LAYERS.
REQ-013 busy  out  1; done  out  1 one-cycle pulse; err  out  1 sticky.

Function
REQ-014 SHALL hold MAX_LAYERS descriptors {base, in, out, valid}; write on cfg_we when not busy; writes while busy ignored.
REQ-015 SHALL set a descriptor's valid bit on write iff in and out are nonzero multiples of 4, else clear it.
REQ-016 SHALL implement states IDLE, CHECK, LAUNCH, RUN, FINISH, ERROR.
REQ-017 IDLE: start=1 -> CHECK next cycle, latch cfg_num_layers, clear err, layer_index=0; layer_done ignored.
REQ-018 CHECK: num_layers in 1..MAX_LAYERS and descriptors 0..num_layers-1 all valid -> LAUNCH; else -> ERROR.
REQ-019 LAUNCH: layer_start=1 for exactly this cycle; -> RUN.
REQ-020 Layer outputs SHALL be registered, valid from LAUNCH cycle, stable through RUN.
REQ-021 kernel_input_count SHALL equal layer_input_layersize*KERNEL_MULT, zero-extended, no truncation.
REQ-022 layer_zero_address SHALL equal ZERO_ADDRESS at all times after reset.
REQ-023 RUN: layer_done=1 with layer_index<num_layers-1 -> LAUNCH, layer_index+1; with layer_index=num_layers-1 -> FINISH.
REQ-024 FINISH: done=1 this cycle only; -> IDLE; layer outputs retain last values.
REQ-025 ERROR: err=1 (sticky until next accepted start); -> IDLE after one cycle; no layer_start issued.
REQ-026 busy SHALL be 1 in CHECK, LAUNCH, RUN, FINISH; start while busy ignored.
REQ-027 abort=1 in any non-IDLE state -> IDLE next cycle, no done, no layer_start; abort has priority over layer_done.
REQ-028 layer_done outside RUN SHALL be ignored.
REQ-029 Latency: start at cycle T -> layer_start at T+2; layer_done at D -> next layer_start at D+1, or done at D+1.

Reset
REQ-030 On reset assertion all outputs SHALL go 0 immediately except layer_zero_address=ZERO_ADDRESS; state IDLE; all valid bits cleared.
REQ-031 Reset mid-run SHALL abandon the run; no done or layer_start until a new start after deassertion.

Verification
REQ-032 Write idx0 {32'h00080000,10,16}: start -> CHECK fails (10 not multiple of 4) -> err=1, no layer_start, busy 2 cycles.
REQ-033 Write idx0 {32'h00080000,12,16}, idx1 {32'h00090000,16,8}, num=2, start at T -> layer_start T+2 with base 80000, kernel_input_count 60; layer_done -> layer_start next cycle with base 90000, count 80; layer_done -> done one cycle later.
REQ-034 num_layers=0 and num_layers=9 -> err=1, idle, no layer_start.
REQ-035 abort during RUN of layer 1 concurrent with layer_done -> IDLE, no done, no further layer_start; new start runs from layer 0.
REQ-036 cfg_we while busy changing idx1 -> layer 1 uses original values; start pulses while busy ignored.
REQ-037 s_axis_aresetn low mid-RUN -> outputs 0 asynchronously, layer_zero_address=32'h00070000; later start with unwritten table -> err=1.

Source files
------------

// File: rtl/kan_layer_sequencer.sv
// Sequences a multi-layer KAN inference: validates a small descriptor table,
// then launches each layer in turn and waits for its completion.
module kan_layer_sequencer #(
  parameter int unsigned ADDRWIDTH     = 32,
  parameter int unsigned LG_LAYERSIZE  = 12,
  parameter int unsigned MAX_LAYERS    = 8,
  parameter int unsigned LG_MAX_LAYERS = 3,
  parameter int unsigned KERNEL_MULT   = 5,
  parameter logic [ADDRWIDTH-1:0] ZERO_ADDRESS = 32'h00070000
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_aresetn,
  input  logic                     cfg_we,
  input  logic [LG_MAX_LAYERS-1:0] cfg_idx,
  input  logic [ADDRWIDTH-1:0]     cfg_base_address,
  input  logic [LG_LAYERSIZE-1:0]  cfg_input_layersize,
  input  logic [LG_LAYERSIZE-1:0]  cfg_output_layersize,
  input  logic [LG_MAX_LAYERS:0]   cfg_num_layers,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     layer_done,
  output logic                     layer_start,
  output logic [ADDRWIDTH-1:0]     layer_base_address,
  output logic [ADDRWIDTH-1:0]     layer_zero_address,
  output logic [LG_LAYERSIZE-1:0]  layer_input_layersize,
  output logic [LG_LAYERSIZE-1:0]  layer_output_layersize,
  output logic [LG_LAYERSIZE+2:0]  kernel_input_count,
  output logic [LG_MAX_LAYERS-1:0] layer_index,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned KW = LG_LAYERSIZE + 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_FINISH = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [ADDRWIDTH-1:0]    desc_base [MAX_LAYERS];
  logic [LG_LAYERSIZE-1:0] desc_in   [MAX_LAYERS];
  logic [LG_LAYERSIZE-1:0] desc_out  [MAX_LAYERS];
  logic [MAX_LAYERS-1:0]   desc_valid;

  logic [LG_MAX_LAYERS:0]   num_layers;
  logic                     check_ok;
  logic                     is_last;
  logic                     load_en;
  logic [LG_MAX_LAYERS-1:0] load_idx;
  logic                     accept_start;
  logic                     desc_wr;
  logic                     wr_ok;

  assign layer_zero_address = ZERO_ADDRESS;
  assign layer_start        = (state == S_LAUNCH);
  assign done               = (state == S_FINISH);
  // ERROR counts as busy so a failed check reports busy for two cycles.
  assign busy               = (state != S_IDLE);
  assign accept_start       = (state == S_IDLE) && start;
  assign desc_wr            = cfg_we && !busy;
  assign wr_ok              = (cfg_input_layersize != '0) && (cfg_input_layersize[1:0] == 2'b00) &&
                              (cfg_output_layersize != '0) && (cfg_output_layersize[1:0] == 2'b00);
  assign is_last            = ({1'b0, layer_index} == (num_layers - (LG_MAX_LAYERS+1)'(1)));

  always_comb begin
    int unsigned num_ext;
    num_ext  = 32'(num_layers);
    check_ok = (num_ext != 0) && (num_ext <= MAX_LAYERS);
    for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
      if ((i < num_ext) && !desc_valid[i[LG_MAX_LAYERS-1:0]]) check_ok = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    load_idx   = '0;
    unique case (state)
      S_IDLE:   if (start) state_next = S_CHECK;
      S_CHECK: begin
        if (abort) state_next = S_IDLE;
        else if (check_ok) begin
          state_next = S_LAUNCH;
          load_en    = 1'b1;
        end else state_next = S_ERROR;
      end
      S_LAUNCH: state_next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort) state_next = S_IDLE;
        else if (layer_done) begin
          if (is_last) state_next = S_FINISH;
          else begin
            state_next = S_LAUNCH;
            load_en    = 1'b1;
            load_idx   = layer_index + LG_MAX_LAYERS'(1);
          end
        end
      end
      S_FINISH: state_next = S_IDLE;
      S_ERROR:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state                  <= S_IDLE;
      num_layers             <= '0;
      err                    <= 1'b0;
      layer_index            <= '0;
      layer_base_address     <= '0;
      layer_input_layersize  <= '0;
      layer_output_layersize <= '0;
      kernel_input_count     <= '0;
      desc_valid             <= '0;
    end else begin
      state <= state_next;
      if (accept_start) begin
        num_layers  <= cfg_num_layers;
        err         <= 1'b0;
        layer_index <= '0;
      end
      if ((state == S_CHECK) && !abort && !check_ok) err <= 1'b1;
      if (load_en) begin
        layer_index            <= load_idx;
        layer_base_address     <= desc_base[load_idx];
        layer_input_layersize  <= desc_in[load_idx];
        layer_output_layersize <= desc_out[load_idx];
        kernel_input_count     <= KW'(desc_in[load_idx]) * KW'(KERNEL_MULT);
      end
      if (desc_wr) desc_valid[cfg_idx] <= wr_ok;
    end
  end

  // Payload fields need no reset: they are only read once their valid bit is set.
  always_ff @(posedge s_axis_aclk) begin
    if (desc_wr) begin
      desc_base[cfg_idx] <= cfg_base_address;
      desc_in[cfg_idx]   <= cfg_input_layersize;
      desc_out[cfg_idx]  <= cfg_output_layersize;
    end
  end

endmodule

// File: tb/tb_kan_layer_sequencer.sv
// Directed self-checking bench for kan_layer_sequencer.
module tb_kan_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_base_address;
  logic [11:0] cfg_input_layersize;
  logic [11:0] cfg_output_layersize;
  logic [3:0]  cfg_num_layers;
  logic        start, abort, layer_done;
  logic        layer_start;
  logic [31:0] layer_base_address, layer_zero_address;
  logic [11:0] layer_input_layersize, layer_output_layersize;
  logic [14:0] kernel_input_count;
  logic [2:0]  layer_index;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kan_layer_sequencer #(
    .ADDRWIDTH(32), .LG_LAYERSIZE(12), .MAX_LAYERS(8), .LG_MAX_LAYERS(3),
    .KERNEL_MULT(5), .ZERO_ADDRESS(32'h00070000)
  ) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base_address(cfg_base_address),
    .cfg_input_layersize(cfg_input_layersize), .cfg_output_layersize(cfg_output_layersize),
    .cfg_num_layers(cfg_num_layers), .start(start), .abort(abort), .layer_done(layer_done),
    .layer_start(layer_start), .layer_base_address(layer_base_address),
    .layer_zero_address(layer_zero_address), .layer_input_layersize(layer_input_layersize),
    .layer_output_layersize(layer_output_layersize), .kernel_input_count(kernel_input_count),
    .layer_index(layer_index), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_desc(input logic [2:0] idx, input logic [31:0] base,
                         input logic [11:0] nin, input logic [11:0] nout);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base_address = base;
    cfg_input_layersize = nin; cfg_output_layersize = nout;
    tick();
    cfg_we = 1'b0;
  endtask

  // Leaves the DUT in the CHECK cycle.
  task automatic kick(input logic [3:0] num);
    cfg_num_layers = num; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_error(input string tag);
    check({tag, "_chk_busy"}, busy, 1);
    tick();
    check({tag, "_err"}, err, 1);
    check({tag, "_err_busy"}, busy, 1);
    check({tag, "_no_ls"}, layer_start, 0);
    tick();
    check({tag, "_idle"}, busy, 0);
    check({tag, "_err_sticky"}, err, 1);
    check({tag, "_no_ls2"}, layer_start, 0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_base_address = '0;
    cfg_input_layersize = '0; cfg_output_layersize = '0; cfg_num_layers = '0;
    start = 1'b0; abort = 1'b0; layer_done = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_zero", layer_zero_address, 32'h00070000);
    check("rst_base", layer_base_address, 0);
    rst_n = 1'b1;
    tick();

    // Input size 10 is not a multiple of 4.
    wr_desc(3'd0, 32'h00080000, 12'd10, 12'd16);
    kick(4'd1);
    expect_error("bad_size");

    // Two-layer run.
    wr_desc(3'd0, 32'h00080000, 12'd12, 12'd16);
    wr_desc(3'd1, 32'h00090000, 12'd16, 12'd8);
    layer_done = 1'b1; tick(); layer_done = 1'b0;
    check("idle_done_ign", done, 0);
    kick(4'd2);
    check("run_err_clr", err, 0);
    check("chk_no_ls", layer_start, 0);
    tick();
    check("l0_ls", layer_start, 1);
    check("l0_base", layer_base_address, 32'h00080000);
    check("l0_kic", kernel_input_count, 60);
    check("l0_in", layer_input_layersize, 12);
    check("l0_out", layer_output_layersize, 16);
    check("l0_idx", layer_index, 0);
    tick();
    check("l0_run_ls", layer_start, 0);
    // Writes and start while busy must not disturb the run.
    wr_desc(3'd1, 32'h000A0000, 12'd20, 12'd20);
    start = 1'b1; cfg_num_layers = 4'd1; tick(); start = 1'b0;
    check("l0_stable", layer_base_address, 32'h00080000);
    layer_done = 1'b1; tick(); layer_done = 1'b0;
    check("l1_ls", layer_start, 1);
    check("l1_base", layer_base_address, 32'h00090000);
    check("l1_kic", kernel_input_count, 80);
    check("l1_idx", layer_index, 1);
    tick();
    layer_done = 1'b1; tick(); layer_done = 1'b0;
    check("fin_done", done, 1);
    check("fin_ls", layer_start, 0);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_base", layer_base_address, 32'h00090000);

    kick(4'd0);
    expect_error("num0");
    kick(4'd9);
    expect_error("num9");

    // Abort concurrent with layer_done on layer 1.
    kick(4'd2);
    tick();
    tick();
    layer_done = 1'b1; tick(); layer_done = 1'b0;
    check("ab_l1_ls", layer_index, 1);
    tick();
    abort = 1'b1; layer_done = 1'b1; tick(); abort = 1'b0; layer_done = 1'b0;
    check("ab_idle", busy, 0);
    check("ab_no_done", done, 0);
    check("ab_no_ls", layer_start, 0);
    tick();
    check("ab_no_done2", done, 0);
    check("ab_no_ls2", layer_start, 0);
    kick(4'd2);
    tick();
    check("ab_restart_ls", layer_start, 1);
    check("ab_restart_idx", layer_index, 0);
    check("ab_restart_base", layer_base_address, 32'h00080000);
    abort = 1'b1; tick(); abort = 1'b0;

    // Largest legal size: 4092*5 = 20460 needs all 15 bits.
    wr_desc(3'd0, 32'h000B0000, 12'd4092, 12'd4);
    kick(4'd1);
    tick();
    check("max_kic", kernel_input_count, 20460);
    tick();
    layer_done = 1'b1; tick(); layer_done = 1'b0;
    check("max_done", done, 1);
    tick();

    // Reset in the middle of a run.
    kick(4'd1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_base", layer_base_address, 0);
    check("mr_kic", kernel_input_count, 0);
    check("mr_zero", layer_zero_address, 32'h00070000);
    check("mr_ls", layer_start, 0);
    #10 rst_n = 1'b1;
    tick();
    check("mr_after_done", done, 0);
    kick(4'd1);
    expect_error("mr_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
